uart_link_ctl: RTL
==================

# uart_link_ctl

Sequencer for one board-to-board UART link in the multiplayer Tetris design. It replaces the button-driven `rd_uart`/`wr_uart` strobes. Periodically it snapshots the 32-bit status word (board ID + BCD points) and writes it as a framed 5-byte burst into the UART TX FIFO. On the receive side it drains the UART RX FIFO, hunts for frame headers, and reassembles remote 32-bit words for `board_ID`/`char_rom_16x16`. One instance sits beside each `uart` instance, all in the `pclk` (75 MHz) domain.

## Interface
Parameters:
- `PERIOD`, 750_000: `pclk` cycles between transmit snapshots (10 ms at 75 MHz).
- `HEADER`, 8'hA5: frame start byte.
- `RX_TIMEOUT`, 75_000: maximum idle gap, in cycles, between bytes inside a frame.
- `LINK_TIMEOUT`, 7_500_000: cycles without a good frame before `link_up` drops.

Ports:
- `pclk` in 1: clock; one clock for the whole block.
- `rst` in 1: reset, synchronous, active-high.
- `tx_en` in 1: enables periodic transmission.
- `tx_data` in 32: word to send; sampled only at snapshot.
- `tx_full` in 1: UART TX FIFO full.
- `wr_uart` out 1: one-cycle TX FIFO push.
- `din` out 8: byte presented with `wr_uart`.
- `rx_empty` in 1: UART RX FIFO empty.
- `rx_byte` in 8: RX FIFO head (first-word fall-through), valid while `rx_empty`=0.
- `rd_uart` out 1: one-cycle RX FIFO pop.
- `rx_frame` out 32: last complete received word.
- `rx_valid` out 1: one-cycle strobe when `rx_frame` updates.
- `link_up` out 1: a good frame arrived within the last `LINK_TIMEOUT` cycles.
- `err_cnt` out 8: saturating count of aborted frames.

## Operation
- **Period timer:** free-running down-counter, reloads to `PERIOD-1`. Emits `tick` on reaching 0. When `tx_en`=1, a tick sets `tx_pend`. `tx_pend` is one deep; extra ticks while it is set are dropped.
- **TX FSM (TX_IDLE, TX_LOAD, TX_PUSH, TX_GAP):**
  - TX_IDLE: if `tx_pend`, go to TX_LOAD.
  - TX_LOAD: shadow register <= `tx_data`; clear `tx_pend`; `idx`=0; go to TX_PUSH.
  - TX_PUSH: if `tx_full`=0, assert `wr_uart` with `din` = byte `idx` and go to TX_GAP. Otherwise stay.
    - Byte order: `idx` 0 = `HEADER`, 1 = shadow[31:24], 2 = [23:16], 3 = [15:8], 4 = [7:0].
  - TX_GAP: exactly one cycle. Gives `tx_full` time to update. If `idx`=4, go to TX_IDLE; else `idx`++ and go to TX_PUSH.
  - A tick during a burst sets `tx_pend`; the next burst follows immediately after the current one.
  - Deasserting `tx_en` mid-burst still completes the burst; it only blocks new `tx_pend`.
- **RX FSM (RX_HUNT, RX_DATA, RX_GAP):**
  - A byte is consumed only when `rx_empty`=0. The block samples `rx_byte` and asserts `rd_uart` in the same cycle, then spends one RX_GAP cycle before the next consume.
  - RX_HUNT: non-`HEADER` bytes are popped and discarded. A `HEADER` byte sets `cnt`=0 and moves to RX_DATA.
  - RX_DATA: each byte shifts into the assembly register MSB-first and `cnt`++.
    - On the 4th byte: `rx_frame` <= assembled word, `rx_valid`=1 for one cycle, return to RX_HUNT.
    - A `HEADER` value inside the data is treated as data; there is no escaping.
  - Gap counter resets on every consumed byte. If it reaches `RX_TIMEOUT` while in RX_DATA: discard the partial frame, `err_cnt`++ (saturating at 255), go to RX_HUNT.
- **Link watchdog:** `rx_valid` reloads it to `LINK_TIMEOUT` and sets `link_up`=1. When it expires, `link_up`=0.

## Timing
- Reset values: `wr_uart`=0, `din`=0, `rd_uart`=0, `rx_frame`=0, `rx_valid`=0, `link_up`=0, `err_cnt`=0.
  - FSMs reset to TX_IDLE and RX_HUNT; `tx_pend`=0; timer loads `PERIOD-1`.
  - Reset mid-frame abandons the frame with no partial output.
- All outputs are registered.
- TX: tick to `tx_pend` takes 1 cycle. From `tx_pend` to the first `wr_uart`, with no backpressure: TX_IDLE -> TX_LOAD -> TX_PUSH, so `wr_uart` is high in the 3rd cycle.
  - Minimum spacing between pushes is 2 cycles, so an unthrottled burst is 10 cycles.
  - `wr_uart` is never asserted while `tx_full`=1.
- RX: at most one pop every 2 cycles. `rx_valid` is asserted in the cycle after the 4th data pop. `rx_frame` holds its value between strobes.
- Simultaneous events:
  - Tick in the TX_LOAD cycle: it is re-latched into `tx_pend`.
  - Timeout and byte arrival in the same cycle: the byte wins, and the gap counter resets.

## Test plan
- **Nominal TX:** `PERIOD`=20, `tx_en`=1, `tx_data`=32'h01_12_34_56, `tx_full`=0 -> every 20 cycles, `din` sequence A5,01,12,34,56 with `wr_uart` pulses 2 cycles apart.
- **Backpressure:** hold `tx_full`=1 for 15 cycles after the 2nd byte -> no `wr_uart` while it is high; bytes 3-5 resume in order, and nothing is lost or duplicated.
- **RX reassembly with junk:** FIFO holds 3C,A5,02,00,09,87 -> 3C discarded, `rx_frame`=32'h02000987, one-cycle `rx_valid`, `link_up`=1, 6 `rd_uart` pulses total.
- **RX timeout:** A5,02 then silence for `RX_TIMEOUT`+1 cycles, then A5,11,22,33,44 -> `err_cnt`=1, `rx_frame`=32'h11223344.
- **Link loss and reset:** after a good frame, wait `LINK_TIMEOUT` with no input -> `link_up`=0. Assert `rst` mid-burst -> `wr_uart`=0 next cycle, and the next burst starts with A5.

Source files
------------

// File: rtl/uart_link_ctl.sv
// uart_link_ctl: periodic framed TX of a status word and RX frame reassembly for one UART link
module uart_link_ctl #(
  parameter int         PERIOD       = 750_000,
  parameter logic [7:0] HEADER       = 8'hA5,
  parameter int         RX_TIMEOUT   = 75_000,
  parameter int         LINK_TIMEOUT = 7_500_000
) (
  input  logic        pclk_i,
  input  logic        rst_i,
  input  logic        tx_en_i,
  input  logic [31:0] tx_data_i,
  input  logic        tx_full_i,
  output logic        wr_uart_o,
  output logic [7:0]  din_o,
  input  logic        rx_empty_i,
  input  logic [7:0]  rx_byte_i,
  output logic        rd_uart_o,
  output logic [31:0] rx_frame_o,
  output logic        rx_valid_o,
  output logic        link_up_o,
  output logic [7:0]  err_cnt_o
);
  localparam int TW = $clog2(PERIOD);
  localparam int GW = $clog2(RX_TIMEOUT + 1);
  localparam int LW = $clog2(LINK_TIMEOUT);
  typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_PUSH, TX_GAP} tx_st_t;
  typedef enum logic [1:0] {RX_HUNT, RX_DATA, RX_GAP} rx_st_t;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          tick;
  tx_st_t        tx_st_q;
  logic          tx_pend_q, tx_pend_d;
  logic [31:0]   sh_q;
  logic [2:0]    idx_q;
  logic [7:0]    byte_d;
  rx_st_t        rx_st_q;
  logic          act_q, done_q;
  logic [1:0]    cnt_q;
  logic [31:0]   asm_q;
  logic [GW-1:0] gap_q, gap_d;
  logic          take, tout, frame_ok;
  logic [LW-1:0] wd_q;
  assign tick      = tmr_q == '0;
  assign tmr_d     = tick ? TW'(PERIOD - 1) : tmr_q - 1'b1;
  assign tx_pend_d = (tick && tx_en_i) || (tx_pend_q && tx_st_q != TX_LOAD);
  assign byte_d    = idx_q == 3'd0 ? HEADER :
                     idx_q == 3'd1 ? sh_q[31:24] :
                     idx_q == 3'd2 ? sh_q[23:16] :
                     idx_q == 3'd3 ? sh_q[15:8] : sh_q[7:0];
  assign take      = !rx_empty_i && rx_st_q != RX_GAP;
  assign tout      = rx_st_q == RX_DATA && rx_empty_i && gap_q == GW'(RX_TIMEOUT);
  assign gap_d     = take ? '0 : gap_q == GW'(RX_TIMEOUT) ? gap_q : gap_q + 1'b1;
  assign frame_ok  = rx_st_q == RX_GAP && done_q;
  // free-running snapshot period timer
  always_ff @(posedge pclk_i)
    tmr_q <= rst_i ? TW'(PERIOD - 1) : tmr_d;
  // TX burst sequencer: header plus four payload bytes, one idle cycle after each push
  always_ff @(posedge pclk_i)
    if (rst_i) begin
      tx_st_q   <= TX_IDLE;
      tx_pend_q <= 1'b0;
      sh_q      <= '0;
      idx_q     <= '0;
      wr_uart_o <= 1'b0;
      din_o     <= '0;
    end else begin
      tx_pend_q <= tx_pend_d;
      wr_uart_o <= 1'b0;
      case (tx_st_q)
        TX_IDLE: if (tx_pend_q) tx_st_q <= TX_LOAD;
        TX_LOAD: begin
          sh_q    <= tx_data_i;
          idx_q   <= '0;
          tx_st_q <= TX_PUSH;
        end
        TX_PUSH: if (!tx_full_i) begin
          wr_uart_o <= 1'b1;
          din_o     <= byte_d;
          tx_st_q   <= TX_GAP;
        end
        default: begin
          idx_q   <= idx_q + 1'b1;
          tx_st_q <= idx_q == 3'd4 ? TX_IDLE : TX_PUSH;
        end
      endcase
    end
  // RX frame hunter: header sync, MSB-first assembly, abort on inter-byte silence
  always_ff @(posedge pclk_i)
    if (rst_i) begin
      rx_st_q    <= RX_HUNT;
      act_q      <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      asm_q      <= '0;
      gap_q      <= '0;
      rd_uart_o  <= 1'b0;
      rx_frame_o <= '0;
      rx_valid_o <= 1'b0;
      err_cnt_o  <= '0;
    end else begin
      gap_q      <= gap_d;
      rd_uart_o  <= take;
      rx_valid_o <= 1'b0;
      done_q     <= 1'b0;
      case (rx_st_q)
        RX_HUNT: if (take) begin
          act_q   <= rx_byte_i == HEADER;
          cnt_q   <= '0;
          rx_st_q <= RX_GAP;
        end
        RX_DATA: if (take) begin
          asm_q   <= {asm_q[23:0], rx_byte_i};
          cnt_q   <= cnt_q + 1'b1;
          act_q   <= cnt_q != 2'd3;
          done_q  <= cnt_q == 2'd3;
          rx_st_q <= RX_GAP;
        end else if (tout) begin
          act_q     <= 1'b0;
          err_cnt_o <= err_cnt_o + 8'(err_cnt_o != 8'hFF);
          rx_st_q   <= RX_HUNT;
        end
        default: begin
          rx_st_q <= act_q ? RX_DATA : RX_HUNT;
          if (done_q) begin
            rx_frame_o <= asm_q;
            rx_valid_o <= 1'b1;
          end
        end
      endcase
    end
  // link watchdog: each good frame keeps link_up high for LINK_TIMEOUT cycles
  always_ff @(posedge pclk_i)
    if (rst_i) begin
      wd_q      <= '0;
      link_up_o <= 1'b0;
    end else if (frame_ok) begin
      wd_q      <= LW'(LINK_TIMEOUT - 1);
      link_up_o <= 1'b1;
    end else if (wd_q != '0) begin
      wd_q <= wd_q - 1'b1;
    end else begin
      link_up_o <= 1'b0;
    end
endmodule
